// File: rtl/clock_pkg.sv
// Shared types and helpers for the multi-alarm clock.
// Hour/minute pairs and per-slot alarm state.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZED
  } alarm_state_e;

  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
  } hm_t;

  // m is a non-negative minute offset; result wraps at 24h
  function automatic hm_t hm_add_min(hm_t t, int m);
    hm_t r;
    int  mm;
    int  hh;
    mm = int'(t.min) + (m % 60);
    hh = int'(t.hour) + ((m / 60) % 24);
    if (mm > 59) begin
      mm = mm - 60;
      hh = hh + 1;
    end
    if (hh > 23) hh = hh - 24;
    r.hour = 5'(hh);
    r.min  = 6'(mm);
    return r;
  endfunction

  // single-field step, wraps inside the field, no carry
  function automatic hm_t hm_step(hm_t t, logic hr, logic up);
    hm_t r;
    r = t;
    if (hr) begin
      if (up) r.hour = (t.hour == HOUR_MAX) ? 5'd0 : t.hour + 5'd1;
      else    r.hour = (t.hour == 5'd0) ? HOUR_MAX : t.hour - 5'd1;
    end else begin
      if (up) r.min = (t.min == MIN_MAX) ? 6'd0 : t.min + 6'd1;
      else    r.min = (t.min == 6'd0) ? MIN_MAX : t.min - 6'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_alarm_clock_alarm_slot.sv
// One alarm slot: stored time, enable, snooze wake time
// and the IDLE/RINGING/SNOOZED state machine.
module alarm_slot
  import clock_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sel,
  input  logic inc_p,
  input  logic dec_p,
  input  logic field_hr,
  input  logic en_toggle_p,
  input  logic snooze_p,
  input  logic stop_p,
  input  logic min_roll,
  input  hm_t  now_hm,
  input  hm_t  next_hm,
  output hm_t  hm_nxt,
  output logic en,
  output logic ringing,
  output logic snoozed
);

  localparam logic [5:0] RING_LAST = 6'(RING_MIN - 1);

  alarm_state_e st_q, st_d;
  logic         en_q, en_d;
  hm_t          hm_q, hm_d;
  hm_t          wake_q, wake_d;
  logic [5:0]   cnt_q, cnt_d;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      en_q   <= 1'b0;
      hm_q   <= '0;
      wake_q <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      en_q   <= en_d;
      hm_q   <= hm_d;
      wake_q <= wake_d;
      cnt_q  <= cnt_d;
    end
  end

  // edits, enable toggle and ring/snooze transitions
  always_comb begin
    st_d   = st_q;
    en_d   = en_q;
    hm_d   = hm_q;
    wake_d = wake_q;
    cnt_d  = cnt_q;
    if (sel && (inc_p ^ dec_p)) hm_d = hm_step(hm_q, field_hr, inc_p);
    if (sel && en_toggle_p) en_d = ~en_q;
    unique case (st_q)
      IDLE: begin
        if (min_roll && next_hm == hm_q) begin
          st_d  = RINGING;
          cnt_d = '0;
        end
      end
      RINGING: begin
        if (stop_p) begin
          st_d = IDLE;
        end else if (snooze_p) begin
          st_d   = SNOOZED;
          wake_d = hm_add_min(now_hm, SNOOZE_MIN);
        end else if (min_roll) begin
          if (cnt_q == RING_LAST) st_d = IDLE;
          else cnt_d = cnt_q + 6'd1;
        end
      end
      SNOOZED: begin
        if (stop_p) begin
          st_d = IDLE;
        end else if (min_roll && next_hm == wake_q) begin
          st_d  = RINGING;
          cnt_d = '0;
        end
      end
      default: st_d = IDLE;
    endcase
    if (!en_d) st_d = IDLE;
  end

  assign hm_nxt  = hm_d;
  assign en      = en_q;
  assign ringing = (st_q == RINGING);
  assign snoozed = (st_q == SNOOZED);

endmodule

// File: rtl/multi_alarm_clock.sv
// 24h time-of-day counter with N independent alarm slots.
// Prescaler, time counter, edit decode and display mux.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter  int CLK_HZ     = 100_000_000,
  parameter  int N_ALARMS   = 4,
  parameter  int SNOOZE_MIN = 5,
  parameter  int RING_MIN   = 1,
  localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_time,
  input  logic                edit_alarm,
  input  logic [AW-1:0]       alarm_sel,
  input  logic                field_hr,
  input  logic                inc_p,
  input  logic                dec_p,
  input  logic                en_toggle_p,
  input  logic                snooze_p,
  input  logic                stop_p,
  output logic [4:0]          disp_hour,
  output logic [5:0]          disp_min,
  output logic [5:0]          disp_sec,
  output logic                sec_tick,
  output logic [N_ALARMS-1:0] alarm_en,
  output logic [N_ALARMS-1:0] ringing,
  output logic [N_ALARMS-1:0] snoozed
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PLAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  hm_t           time_q, time_d;
  logic [5:0]    sec_q, sec_d;
  logic          pend_q, pend_d;
  logic [4:0]    dhour_q, dhour_d;
  logic [5:0]    dmin_q, dmin_d;
  logic [5:0]    dsec_q, dsec_d;

  logic tick_raw;
  logic clk_edit;
  logic due;
  logic tick_apply;
  logic min_roll;
  hm_t  tgt;

  hm_t                 slot_hm [N_ALARMS];
  logic [N_ALARMS-1:0] slot_sel;

  // time, prescaler, pending tick and display registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      time_q  <= '0;
      sec_q   <= '0;
      pend_q  <= 1'b0;
      dhour_q <= '0;
      dmin_q  <= '0;
      dsec_q  <= '0;
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
      sec_q   <= sec_d;
      pend_q  <= pend_d;
      dhour_q <= dhour_d;
      dmin_q  <= dmin_d;
      dsec_q  <= dsec_d;
    end
  end

  // a clock edit defers a coincident tick by one cycle
  always_comb begin
    tick_raw   = (presc_q == PLAST);
    sec_tick   = tick_raw & ~clr_time;
    clk_edit   = ~edit_alarm & (inc_p ^ dec_p);
    due        = sec_tick | pend_q;
    tick_apply = due & ~clk_edit & ~clr_time;
    pend_d     = ~clr_time & due & clk_edit;
    presc_d    = (clr_time || tick_raw) ? '0 : presc_q + PW'(1);
    min_roll   = tick_apply & (sec_q == MIN_MAX);
    time_d     = time_q;
    sec_d      = sec_q;
    if (clr_time) begin
      time_d = '0;
      sec_d  = '0;
    end else if (clk_edit) begin
      time_d = hm_step(time_q, field_hr, inc_p);
    end else if (tick_apply) begin
      if (sec_q == MIN_MAX) begin
        sec_d = '0;
        if (time_q.min == MIN_MAX) begin
          time_d.min  = '0;
          time_d.hour = (time_q.hour == HOUR_MAX) ? 5'd0 : time_q.hour + 5'd1;
        end else begin
          time_d.min = time_q.min + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // display follows the post-edge value of the selected target
  always_comb begin
    tgt = time_d;
    if (edit_alarm) begin
      tgt = '0;
      if (int'(alarm_sel) < N_ALARMS) tgt = slot_hm[alarm_sel];
    end
    dhour_d = tgt.hour;
    dmin_d  = tgt.min;
    dsec_d  = edit_alarm ? 6'd0 : sec_d;
  end

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_slot
    assign slot_sel[i] = edit_alarm & (alarm_sel == AW'(i));
    alarm_slot #(
      .SNOOZE_MIN(SNOOZE_MIN),
      .RING_MIN  (RING_MIN)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .sel        (slot_sel[i]),
      .inc_p      (inc_p),
      .dec_p      (dec_p),
      .field_hr   (field_hr),
      .en_toggle_p(en_toggle_p),
      .snooze_p   (snooze_p),
      .stop_p     (stop_p),
      .min_roll   (min_roll),
      .now_hm     (time_q),
      .next_hm    (time_d),
      .hm_nxt     (slot_hm[i]),
      .en         (alarm_en[i]),
      .ringing    (ringing[i]),
      .snoozed    (snoozed[i])
    );
  end

  assign disp_hour = dhour_q;
  assign disp_min  = dmin_q;
  assign disp_sec  = dsec_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock, CLK_HZ=10.
// Inputs driven and outputs sampled on the falling edge.
module tb_multi_alarm_clock;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_time = 1'b0;
  logic       edit_alarm = 1'b0;
  logic [1:0] alarm_sel = 2'd0;
  logic       field_hr = 1'b0;
  logic       inc_p = 1'b0;
  logic       dec_p = 1'b0;
  logic       en_toggle_p = 1'b0;
  logic       snooze_p = 1'b0;
  logic       stop_p = 1'b0;
  logic [4:0] disp_hour;
  logic [5:0] disp_min;
  logic [5:0] disp_sec;
  logic       sec_tick;
  logic [3:0] alarm_en;
  logic [3:0] ringing;
  logic [3:0] snoozed;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] P_INC  = 5'b00001;
  localparam logic [4:0] P_DEC  = 5'b00010;
  localparam logic [4:0] P_EN   = 5'b00100;
  localparam logic [4:0] P_SNZ  = 5'b01000;
  localparam logic [4:0] P_STOP = 5'b10000;

  multi_alarm_clock #(
    .CLK_HZ    (10),
    .N_ALARMS  (4),
    .SNOOZE_MIN(5),
    .RING_MIN  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_time   (clr_time),
    .edit_alarm (edit_alarm),
    .alarm_sel  (alarm_sel),
    .field_hr   (field_hr),
    .inc_p      (inc_p),
    .dec_p      (dec_p),
    .en_toggle_p(en_toggle_p),
    .snooze_p   (snooze_p),
    .stop_p     (stop_p),
    .disp_hour  (disp_hour),
    .disp_min   (disp_min),
    .disp_sec   (disp_sec),
    .sec_tick   (sec_tick),
    .alarm_en   (alarm_en),
    .ringing    (ringing),
    .snoozed    (snoozed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [4:0] m);
    {stop_p, snooze_p, en_toggle_p, dec_p, inc_p} = m;
    @(negedge clk);
    {stop_p, snooze_p, en_toggle_p, dec_p, inc_p} = '0;
  endtask

  task automatic pulses(input logic [4:0] m, input int n);
    for (int i = 0; i < n; i++) pulse(m);
  endtask

  task automatic chk_time(input string tag, input int h, input int m,
                          input int s);
    chk({tag, "_h"}, 32'(disp_hour), h);
    chk({tag, "_m"}, 32'(disp_min), m);
    chk({tag, "_s"}, 32'(disp_sec), s);
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!sec_tick && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tick_wait", 32'(n < 40), 1);
    @(negedge clk);
  endtask

  task automatic wait_time(input int h, input int m, input int s);
    int n = 0;
    while (!(int'(disp_hour) == h && int'(disp_min) == m &&
             int'(disp_sec) == s) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("time_wait", 32'(n < 5000), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hour"}, 32'(disp_hour), 0);
    chk({tag, "_min"}, 32'(disp_min), 0);
    chk({tag, "_sec"}, 32'(disp_sec), 0);
    chk({tag, "_tick"}, 32'(sec_tick), 0);
    chk({tag, "_en"}, 32'(alarm_en), 0);
    chk({tag, "_ring"}, 32'(ringing), 0);
    chk({tag, "_snz"}, 32'(snoozed), 0);
  endtask

  initial begin
    int nt = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;

    repeat (600) begin
      @(negedge clk);
      if (sec_tick) nt++;
    end
    chk("ticks_600", 32'(nt), 60);
    chk_time("t600", 0, 1, 0);

    for (int i = 0; i < 20 && !sec_tick; i++) @(negedge clk);
    field_hr = 1'b0;
    pulse(P_INC);
    chk_time("coinc_edit", 0, 2, 0);
    @(negedge clk);
    chk("coinc_sec", 32'(disp_sec), 1);

    pulse(P_INC | P_DEC);
    chk("both_ign", 32'(disp_min), 2);

    clr_time = 1'b1;
    @(negedge clk);
    clr_time = 1'b0;
    chk_time("clr", 0, 0, 0);
    field_hr = 1'b1;
    pulse(P_DEC);
    chk("hr_wrap_h", 32'(disp_hour), 23);
    chk("hr_wrap_m", 32'(disp_min), 0);
    field_hr = 1'b0;
    pulse(P_DEC);
    chk("min_wrap", 32'(disp_min), 59);
    wait_time(23, 59, 59);
    wait_tick();
    chk_time("day_wrap", 0, 0, 0);

    edit_alarm = 1'b1;
    alarm_sel  = 2'd2;
    field_hr   = 1'b0;
    pulse(P_DEC);
    chk("a2_min_dn", 32'(disp_min), 59);
    chk("a2_sec0", 32'(disp_sec), 0);
    pulse(P_INC);
    chk("a2_min_up", 32'(disp_min), 0);
    chk("a2_hr", 32'(disp_hour), 0);

    alarm_sel = 2'd0;
    field_hr  = 1'b1;
    pulses(P_INC, 6);
    field_hr  = 1'b0;
    pulses(P_INC, 30);
    chk("a0_h", 32'(disp_hour), 6);
    chk("a0_m", 32'(disp_min), 30);
    pulse(P_EN);
    alarm_sel = 2'd1;
    field_hr  = 1'b1;
    pulses(P_INC, 6);
    field_hr  = 1'b0;
    pulses(P_INC, 30);
    chk("a_en", 32'(alarm_en), 32'b0001);

    edit_alarm = 1'b0;
    clr_time   = 1'b1;
    @(negedge clk);
    clr_time   = 1'b0;
    field_hr   = 1'b1;
    pulses(P_INC, 6);
    field_hr   = 1'b0;
    pulses(P_INC, 29);
    wait_time(6, 29, 59);
    chk("pre_ring", 32'(ringing), 0);
    wait_tick();
    chk_time("ring_at", 6, 30, 0);
    chk("ring0", 32'(ringing), 32'b0001);

    wait_time(6, 30, 10);
    pulse(P_SNZ);
    chk("snz_s", 32'(snoozed), 32'b0001);
    chk("snz_r", 32'(ringing), 0);
    wait_time(6, 34, 59);
    chk("snz_hold", 32'(snoozed), 32'b0001);
    wait_tick();
    chk("wake_r", 32'(ringing), 32'b0001);
    chk("wake_s", 32'(snoozed), 0);
    pulse(P_SNZ);
    chk("snz2", 32'(snoozed), 32'b0001);
    pulse(P_STOP);
    chk("stop_s", 32'(snoozed), 0);
    chk("stop_r", 32'(ringing), 0);

    pulses(P_DEC, 6);
    wait_time(6, 29, 59);
    wait_tick();
    chk("ring_again", 32'(ringing), 32'b0001);
    wait_time(6, 30, 59);
    chk("ring_hold", 32'(ringing), 32'b0001);
    wait_tick();
    chk_time("tmo_at", 6, 31, 0);
    chk("ring_tmo", 32'(ringing), 0);

    pulse(P_DEC);
    chk_time("edit_match", 6, 30, 0);
    @(negedge clk);
    chk("edit_no_trig", 32'(ringing), 0);

    pulse(P_DEC);
    wait_time(6, 29, 59);
    wait_tick();
    chk("ring_pre_rst", 32'(ringing), 32'b0001);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_rst");
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
